// File: rtl/piso_serializer_v2.sv
// Parallel-in/serial-out serializer with a valid/ready input, a one-word hold
// register for gapless streaming, per-word bit order and a programmable bit period.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | line parked at IDLE_LEVEL, shift register empty
// S_SHIFT | a word is on the line; hold register may hold the next word
module piso_serializer_v2 #(
    parameter int   DATA_WIDTH = 8,
    parameter int   DIV_WIDTH  = 8,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  msb_first,
    input  logic [DIV_WIDTH-1:0]  clk_div,
    output logic                  ready,
    output logic                  srl_out,
    output logic                  tx_active,
    output logic                  word_done
);

    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0]        BIT_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0]        BIT_ONE  = BW'(1);
    localparam logic [DIV_WIDTH-1:0] PER_ONE  = DIV_WIDTH'(1);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_msb;
    logic [DIV_WIDTH-1:0]  r_div;
    logic [BW-1:0]         r_bit_cnt;
    logic [DIV_WIDTH-1:0]  r_per_cnt;
    logic [DATA_WIDTH-1:0] r_hold_data;
    logic                  r_hold_msb;
    logic [DIV_WIDTH-1:0]  r_hold_div;
    logic                  r_hold_full;
    logic                  r_srl;
    logic                  r_tx_active;

    logic w_xfer;
    logic w_period_end;
    logic w_last;

    assign w_xfer       = valid & ~r_hold_full;
    assign w_period_end = (r_per_cnt == r_div);
    assign w_last       = (r_state == S_SHIFT) && (r_bit_cnt == BIT_LAST) && w_period_end;

    function automatic logic get_bit(input logic [DATA_WIDTH-1:0] word,
                                     input logic                  msb,
                                     input logic [BW-1:0]         idx);
        get_bit = msb ? word[BIT_LAST - idx] : word[idx];
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_msb       <= 1'b0;
            r_div       <= '0;
            r_bit_cnt   <= '0;
            r_per_cnt   <= '0;
            r_hold_data <= '0;
            r_hold_msb  <= 1'b0;
            r_hold_div  <= '0;
            r_hold_full <= 1'b0;
            r_srl       <= IDLE_LEVEL;
            r_tx_active <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        r_state     <= S_SHIFT;
                        r_tx_active <= 1'b1;
                        r_shift     <= data_in;
                        r_msb       <= msb_first;
                        r_div       <= clk_div;
                        r_bit_cnt   <= '0;
                        r_per_cnt   <= '0;
                        r_srl       <= get_bit(data_in, msb_first, '0);
                    end
                end
                S_SHIFT: begin
                    if (w_last) begin
                        r_bit_cnt <= '0;
                        r_per_cnt <= '0;
                        // Next word comes from hold first; a fresh transfer can only land when hold is empty
                        if (r_hold_full) begin
                            r_shift     <= r_hold_data;
                            r_msb       <= r_hold_msb;
                            r_div       <= r_hold_div;
                            r_hold_full <= 1'b0;
                            r_srl       <= get_bit(r_hold_data, r_hold_msb, '0);
                        end else if (w_xfer) begin
                            r_shift <= data_in;
                            r_msb   <= msb_first;
                            r_div   <= clk_div;
                            r_srl   <= get_bit(data_in, msb_first, '0);
                        end else begin
                            r_state     <= S_IDLE;
                            r_tx_active <= 1'b0;
                            r_srl       <= IDLE_LEVEL;
                        end
                    end else begin
                        if (w_period_end) begin
                            r_per_cnt <= '0;
                            r_bit_cnt <= r_bit_cnt + BIT_ONE;
                            r_srl     <= get_bit(r_shift, r_msb, r_bit_cnt + BIT_ONE);
                        end else begin
                            r_per_cnt <= r_per_cnt + PER_ONE;
                        end
                        if (w_xfer) begin
                            r_hold_data <= data_in;
                            r_hold_msb  <= msb_first;
                            r_hold_div  <= clk_div;
                            r_hold_full <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_tx_active <= 1'b0;
                    r_srl       <= IDLE_LEVEL;
                end
            endcase
        end
    end

    assign ready     = ~r_hold_full;
    assign srl_out   = r_srl;
    assign tx_active = r_tx_active;
    assign word_done = w_last;

endmodule

// File: tb/tb_piso_serializer_v2.sv
// Self-checking bench for piso_serializer_v2: a cycle-level scoreboard of expected
// line bits and word_done pulses, filled at each transfer and drained every clock.
module tb_piso_serializer_v2;

    localparam int DW = 8;
    localparam int VW = 8;

    logic          clk;
    logic          rst;
    logic          valid;
    logic [DW-1:0] data_in;
    logic          msb_first;
    logic [VW-1:0] clk_div;
    logic          ready;
    logic          srl_out;
    logic          tx_active;
    logic          word_done;

    int n_checks = 0;
    int n_pass   = 0;

    // Each entry is one expected line cycle: {word_done, srl_out}
    logic [1:0] exp_q[$];
    int         words_q = 0;
    logic       mon_en  = 1'b0;

    piso_serializer_v2 #(
        .DATA_WIDTH(DW),
        .DIV_WIDTH (VW),
        .IDLE_LEVEL(1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .valid    (valid),
        .data_in  (data_in),
        .msb_first(msb_first),
        .clk_div  (clk_div),
        .ready    (ready),
        .srl_out  (srl_out),
        .tx_active(tx_active),
        .word_done(word_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    endtask

    task automatic push_word(input logic [DW-1:0] d, input logic msb, input logic [VW-1:0] div);
        logic b;
        for (int i = 0; i < DW; i++) begin
            b = msb ? d[DW-1-i] : d[i];
            for (int p = 0; p <= int'(div); p++)
                exp_q.push_back({(i == DW-1) && (p == int'(div)), b});
        end
        words_q++;
    endtask

    // Outputs are stable at the falling edge; inputs change only just after rising edges
    always @(negedge clk) begin
        logic       exp_ready;
        logic [1:0] item;
        if (mon_en && rst) begin
            exp_ready = (words_q < 2);
            check_eq("ready", ready, exp_ready);
            if (exp_q.size() > 0) begin
                item = exp_q.pop_front();
                check_eq("tx_active", tx_active, 1'b1);
                check_eq("srl_out", srl_out, item[0]);
                check_eq("word_done", word_done, item[1]);
                if (item[1]) words_q--;
            end else begin
                check_eq("idle_tx_active", tx_active, 1'b0);
                check_eq("idle_srl_out", srl_out, 1'b1);
                check_eq("idle_word_done", word_done, 1'b0);
            end
            if (valid && exp_ready) push_word(data_in, msb_first, clk_div);
        end
    end

    // Presents a word and returns just after the edge that transfers it
    task automatic send(input logic [DW-1:0] d, input logic msb, input logic keep);
        bit done = 0;
        valid     = 1'b1;
        data_in   = d;
        msb_first = msb;
        for (int t = 0; t < 1000 && !done; t++) begin
            @(negedge clk);
            if (ready) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        if (!done) check_eq("send_timeout", 1'b0, 1'b1);
        if (!keep) valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int t = 0; t < 3000 && !done; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0) done = 1;
        end
        if (!done) check_eq("idle_timeout", 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        valid     = 1'b0;
        data_in   = '0;
        msb_first = 1'b0;
        clk_div   = '0;

        for (int i = 0; i < 4; i++) begin
            valid     = 1'($urandom_range(0, 1));
            data_in   = DW'($urandom);
            msb_first = 1'($urandom_range(0, 1));
            clk_div   = VW'($urandom);
            @(negedge clk);
            check_eq("rst_srl_out", srl_out, 1'b1);
            check_eq("rst_ready", ready, 1'b1);
            check_eq("rst_tx_active", tx_active, 1'b0);
            check_eq("rst_word_done", word_done, 1'b0);
        end
        @(posedge clk);
        #1;
        valid = 1'b0;
        clk_div = '0;
        rst    = 1'b1;
        mon_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // LSB first, one bit per clock
        clk_div = 8'd0;
        send(8'hA5, 1'b0, 1'b0);
        wait_idle();

        // MSB first, four clocks per bit, divider changed mid-word
        clk_div = 8'd3;
        send(8'h3C, 1'b1, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        clk_div = 8'd0;
        wait_idle();

        // Back-to-back through the hold register
        clk_div = 8'd1;
        send(8'hFF, 1'b0, 1'b1);
        send(8'h00, 1'b0, 1'b0);
        wait_idle();

        // Transfer on the word_done cycle with hold empty
        clk_div = 8'd0;
        send(8'hC3, 1'b0, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        check_eq("same_cycle_wd", word_done, 1'b1);
        send(8'h81, 1'b1, 1'b0);
        wait_idle();

        // Reset mid-word with a word waiting in hold
        clk_div = 8'd1;
        send(8'h55, 1'b0, 1'b0);
        send(8'hF0, 1'b1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check_eq("pre_rst_ready", ready, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        check_eq("async_srl_out", srl_out, 1'b1);
        check_eq("async_tx_active", tx_active, 1'b0);
        check_eq("async_ready", ready, 1'b1);
        check_eq("async_word_done", word_done, 1'b0);
        exp_q.delete();
        words_q = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (40) @(posedge clk);
        #1;

        // Random words to finish
        for (int i = 0; i < 6; i++) begin
            clk_div = VW'($urandom_range(0, 2));
            send(DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        valid = 1'b0;
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/piso_serializer_v2.md
Name: piso_serializer_v2

Overview:
Parametrised parallel-in/serial-out serializer with a valid/ready input handshake and a one-word holding register, so back-to-back words go out with no idle gap. Per-word bit order (LSB/MSB first) and a programmable bit period. Sits between the transceiver's word-level datapath and the serial line driver, replacing the fixed 8-bit serializer.

Parameters:
DATA_WIDTH, 8, word width in bits (≥2)
DIV_WIDTH, 8, width of the bit-period divider input
IDLE_LEVEL, 1'b1, srl_out level when no word is being shifted

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
valid  input  1  data_in/msb_first carry a word
data_in  input  DATA_WIDTH  parallel word
msb_first  input  1  bit order for this word: 1 = MSB first, 0 = LSB first
clk_div  input  DIV_WIDTH  each bit lasts clk_div+1 clk cycles
ready  output  1  block can accept a word this cycle
srl_out  output  1  serial data, registered
tx_active  output  1  a word is currently on srl_out
word_done  output  1  one-cycle pulse when the last bit period of a word ends

Behaviour:
- Reset (rst=0, async assert, sync release): srl_out=IDLE_LEVEL, ready=1, tx_active=0, word_done=0, hold empty, state IDLE, bit/period counters 0. Reset mid-word aborts the word; no word_done.
- Transfer occurs on a clock edge with valid=1 and ready=1. ready = !hold_full (registered, combinationally independent of valid). data_in held stable by source only while valid=1 and ready=0.
- Per word captured: data, msb_first, clk_div (changes mid-word have no effect).
- States: IDLE, SHIFT.
- IDLE: on transfer, word goes directly to the shift register; next cycle state=SHIFT, tx_active=1, srl_out = first bit (bit 0 if LSB-first, bit DATA_WIDTH-1 if MSB-first). Latency transfer edge → first bit on srl_out: 1 cycle. Hold register stays empty.
- SHIFT: period counter counts 0..clk_div; at clk_div, the bit counter advances and srl_out takes the next bit. Bit counter counts 0..DATA_WIDTH-1.
- End of last bit period (bit counter = DATA_WIDTH-1, period = clk_div): word_done=1 for that cycle. Then:
  - hold full: hold moves to the shift register, hold becomes empty, ready=1 next cycle, srl_out shows the new first bit next cycle, stay SHIFT (gapless).
  - hold empty and transfer in the same cycle: the new word loads straight into the shift register (gapless), hold stays empty.
  - otherwise: state=IDLE, tx_active=0, srl_out=IDLE_LEVEL next cycle.
- SHIFT with hold empty: a transfer fills hold; ready=0 from the next cycle until hold is consumed.
- Transfer and hold-to-shift move in the same cycle cannot happen: hold full implies ready=0.
- Word on the line = (clk_div+1)*DATA_WIDTH cycles exactly. Continuous stream: no IDLE_LEVEL cycles between words.
- clk_div=0: one bit per clock; all rules above hold.
- Counters are wide enough for DATA_WIDTH-1 and for 2^DIV_WIDTH-1; there is no wrap inside a word.

Test Plan:
- Reset values: hold rst=0 with random inputs → srl_out=1, ready=1, tx_active=0, word_done=0. Release → unchanged until valid.
- LSB-first, clk_div=0: send 8'hA5, msb_first=0 → from the cycle after transfer, srl_out=1,0,1,0,0,1,0,1 on consecutive clocks. word_done on the 8th bit. srl_out=1 and tx_active=0 after.
- MSB-first, clk_div=3: send 8'h3C, msb_first=1 → bits 0,0,1,1,1,1,0,0, each held 4 cycles (32 cycles total). clk_div changed to 0 mid-word → no effect.
- Back-to-back: valid held high with 8'hFF then 8'h00, clk_div=1 → ready drops after the second transfer. srl_out = 16 cycles of 1 then 16 cycles of 0, no idle cycle. Two word_done pulses 16 cycles apart.
- Same-cycle load: hold empty, assert valid with 8'h81 exactly on the word_done cycle of the previous word → the new first bit appears the next cycle, no gap.
- Reset mid-word: assert rst=0 at bit 3 of 8'h55 → srl_out=1, tx_active=0, and ready=1 immediately (async). No word_done. The hold contents are discarded.
